// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, debounce FSM states and key helpers
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hD;
  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } db_state_t;

  // Codes 0..9 are decimal digits; everything above is an edit/command key.
  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - turns the scanner's held level into one event per press
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  output logic       key_event,
  output logic [3:0] key_code
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TERM     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_TERM = CNT_W'(DEBOUNCE_CYCLES - 2);

  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // The event is a strobe on the very edge where the count reaches terminal, so
  // the accumulator in the top updates on that same edge rather than one later.
  assign key_event = (state == ST_PRESS_DB) && key_valid &&
                     (key_val == key_code) && (cnt == PRE_TERM);

  // Press/release debounce FSM with a saturating stable-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      key_code <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            state    <= ST_PRESS_DB;
            key_code <= key_val;
            cnt      <= '0;
          end
        end
        ST_PRESS_DB: begin
          if (!key_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (key_val != key_code) begin
            key_code <= key_val;
            cnt      <= '0;
          end else if (cnt == PRE_TERM) begin
            cnt   <= TERM;
            state <= ST_HELD;
          end else if (cnt != TERM) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!key_valid) begin
            state <= ST_RELEASE_DB;
            cnt   <= '0;
          end
        end
        ST_RELEASE_DB: begin
          if (key_valid) begin
            state <= ST_HELD;
          end else if (cnt == PRE_TERM) begin
            cnt   <= TERM;
            state <= ST_IDLE;
          end else if (cnt != TERM) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - decimal number entry with commit/ack handshake to the IO bus
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int MAX_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             key_en,
  input  logic             key_valid,
  input  logic [3:0]       key_val,
  input  logic             data_ack,
  output logic [WIDTH-1:0] entry_val,
  output logic [2:0]       digit_cnt,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  logic             key_event;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] shifted_in;
  logic [WIDTH-1:0] shifted_out;
  logic             still_pending;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (key_en),
    .key_valid (key_valid),
    .key_val   (key_val),
    .key_event (key_event),
    .key_code  (key_code)
  );

  // x*10 + d as shift-and-add; x/10 for backspace.
  assign shifted_in  = (entry_val << 3) + (entry_val << 1) + WIDTH'(key_code);
  assign shifted_out = entry_val / WIDTH'(10);

  // An ack in the same cycle frees the slot before an enter looks at it.
  assign still_pending = data_valid && !data_ack;

  // Accumulator, edit keys and commit/ack handshake; later assignments win.
  always_ff @(posedge clk or negedge key_en) begin
    if (!key_en) begin
      entry_val  <= '0;
      digit_cnt  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (key_event) begin
        if (is_digit(key_code)) begin
          if (digit_cnt < MAX_CNT) begin
            entry_val <= shifted_in;
            digit_cnt <= digit_cnt + 3'd1;
          end
        end else begin
          case (key_code)
            KEY_BKSP: begin
              if (digit_cnt != 3'd0) begin
                entry_val <= shifted_out;
                digit_cnt <= digit_cnt - 3'd1;
              end
            end
            KEY_CLEAR: begin
              entry_val <= '0;
              digit_cnt <= '0;
            end
            KEY_ENTER: begin
              if (still_pending) begin
                overrun <= 1'b1;
              end else begin
                data_out   <= entry_val;
                data_valid <= 1'b1;
                entry_val  <= '0;
                digit_cnt  <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry
module tb_keypad_entry;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        key_en;
  logic        key_valid;
  logic [3:0]  key_val;
  logic        data_ack;
  logic [15:0] entry_val;
  logic [2:0]  digit_cnt;
  logic [15:0] data_out;
  logic        data_valid;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  int m_entry, m_cnt, m_out;
  bit m_valid, m_ovr, m_armed;

  always #5 clk = ~clk;

  keypad_entry #(
    .WIDTH(16),
    .MAX_DIGITS(4),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .key_en     (key_en),
    .key_valid  (key_valid),
    .key_val    (key_val),
    .data_ack   (data_ack),
    .entry_val  (entry_val),
    .digit_cnt  (digit_cnt),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

  task automatic model_reset();
    m_entry = 0; m_cnt = 0; m_out = 0;
    m_valid = 0; m_ovr = 0; m_armed = 1;
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 0;
      m_ovr   = 0;
    end
  endtask

  task automatic model_key(input int code);
    if (code <= 9) begin
      if (m_cnt < 4) begin
        m_entry = (m_entry * 10 + code) % 65536;
        m_cnt++;
      end
    end else if (code == 14) begin
      if (m_cnt > 0) begin
        m_entry = m_entry / 10;
        m_cnt--;
      end
    end else if (code == 13) begin
      m_entry = 0;
      m_cnt   = 0;
    end else if (code == 15) begin
      if (m_valid) m_ovr = 1;
      else begin
        m_out   = m_entry;
        m_valid = 1;
        m_entry = 0;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic press(input int code, input int n, input int ack_idx);
    bit fires;
    fires = m_armed && (n >= DB);
    key_valid = 1'b1;
    key_val   = 4'(code);
    for (int i = 0; i < n; i++) begin
      data_ack = (i == ack_idx);
      @(posedge clk); #1;
    end
    data_ack = 1'b0;
    if (fires) begin
      if (ack_idx >= 0 && ack_idx <= DB - 1) model_ack();
      model_key(code);
      if (ack_idx > DB - 1 && ack_idx < n) model_ack();
      m_armed = 0;
    end else if (ack_idx >= 0 && ack_idx < n) begin
      model_ack();
    end
  endtask

  task automatic release_key(input int m, input bit ack);
    key_valid = 1'b0;
    for (int i = 0; i < m; i++) begin
      data_ack = ack && (i == 0);
      @(posedge clk); #1;
    end
    data_ack = 1'b0;
    if (ack) model_ack();
    if (m >= DB) m_armed = 1;
  endtask

  task automatic tap(input int code);
    press(code, DB, -1);
    release_key(DB, 1'b0);
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    @(posedge clk); #1;
    data_ack = 1'b0;
    model_ack();
  endtask

  task automatic test_reset();
    key_en = 1'b0; key_valid = 1'b0; key_val = 4'h0; data_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({entry_val, digit_cnt} !== 19'd0) begin
      bad++;
      $display("FAIL reset_entry: got entry=%0d cnt=%0d want 0 0", entry_val, digit_cnt);
    end
    total++;
    if ({data_out, data_valid, overrun} !== 18'd0) begin
      bad++;
      $display("FAIL reset_data: got out=%0d valid=%0b ovr=%0b want 0 0 0", data_out, data_valid, overrun);
    end
    key_en = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_digit_entry();
    tap(1);
    total++;
    if (entry_val !== 16'd1) begin bad++; $display("FAIL entry_1: got %0d want 1", entry_val); end
    tap(2);
    total++;
    if (entry_val !== 16'd12) begin bad++; $display("FAIL entry_12: got %0d want 12", entry_val); end
    tap(3);
    total++;
    if (entry_val !== 16'd123 || digit_cnt !== 3'd3) begin
      bad++; $display("FAIL entry_123: got %0d cnt=%0d want 123 cnt=3", entry_val, digit_cnt);
    end
    tap(15);
    total++;
    if (entry_val !== 16'd0 || data_out !== 16'd123 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL commit_123: got entry=%0d out=%0d valid=%0b want 0 123 1", entry_val, data_out, data_valid);
    end
    ack_pulse();
    total++;
    if (data_valid !== 1'b0) begin bad++; $display("FAIL ack_clear: got valid=%0b want 0", data_valid); end
  endtask

  task automatic test_short_press();
    repeat (10) begin
      press(5, DB - 1, -1);
      release_key(DB, 1'b0);
    end
    total++;
    if (entry_val !== 16'd0 || digit_cnt !== 3'd0) begin
      bad++; $display("FAIL short_press: got entry=%0d cnt=%0d want 0 0", entry_val, digit_cnt);
    end
  endtask

  task automatic test_glitch();
    press(7, DB, -1);
    release_key(2, 1'b0);
    press(7, 3, -1);
    release_key(DB, 1'b0);
    total++;
    if (entry_val !== 16'd7 || digit_cnt !== 3'd1) begin
      bad++; $display("FAIL glitch_one_event: got entry=%0d cnt=%0d want 7 1", entry_val, digit_cnt);
    end
    tap(13);
  endtask

  task automatic test_max_digits();
    tap(9); tap(8); tap(7); tap(6); tap(5);
    total++;
    if (entry_val !== 16'd9876 || digit_cnt !== 3'd4) begin
      bad++; $display("FAIL max_digits: got entry=%0d cnt=%0d want 9876 4", entry_val, digit_cnt);
    end
    tap(14);
    total++;
    if (entry_val !== 16'd987 || digit_cnt !== 3'd3) begin
      bad++; $display("FAIL backspace: got entry=%0d cnt=%0d want 987 3", entry_val, digit_cnt);
    end
    tap(13);
    total++;
    if (entry_val !== 16'd0 || digit_cnt !== 3'd0) begin
      bad++; $display("FAIL clear: got entry=%0d cnt=%0d want 0 0", entry_val, digit_cnt);
    end
  endtask

  task automatic test_overrun();
    tap(4); tap(2); tap(15);
    tap(3); tap(15);
    total++;
    if (overrun !== 1'b1 || data_out !== 16'd42 || entry_val !== 16'd3 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun: got ovr=%0b out=%0d entry=%0d valid=%0b want 1 42 3 1",
               overrun, data_out, entry_val, data_valid);
    end
    ack_pulse();
    total++;
    if (data_valid !== 1'b0 || overrun !== 1'b0) begin
      bad++; $display("FAIL overrun_ack: got valid=%0b ovr=%0b want 0 0", data_valid, overrun);
    end
    tap(13);
  endtask

  task automatic test_ack_same_cycle();
    tap(1); tap(15);
    tap(8);
    press(15, DB, DB - 1);
    total++;
    if (data_out !== 16'd8 || data_valid !== 1'b1 || overrun !== 1'b0 || entry_val !== 16'd0) begin
      bad++;
      $display("FAIL ack_same_cycle: got out=%0d valid=%0b ovr=%0b entry=%0d want 8 1 0 0",
               data_out, data_valid, overrun, entry_val);
    end
    release_key(DB, 1'b0);
  endtask

  task automatic test_reset_mid_held();
    tap(5);
    press(6, DB, -1);
    #2;
    key_en = 1'b0;
    #1;
    total++;
    if ({entry_val, digit_cnt, data_out, data_valid, overrun} !== 37'd0) begin
      bad++;
      $display("FAIL reset_mid_held: got entry=%0d cnt=%0d out=%0d valid=%0b ovr=%0b want all 0",
               entry_val, digit_cnt, data_out, data_valid, overrun);
    end
    key_valid = 1'b0;
    @(posedge clk); #1;
    key_en = 1'b1;
    model_reset();
    @(posedge clk); #1;
    press(2, DB, -1);
    total++;
    if (entry_val !== 16'd2 || digit_cnt !== 3'd1) begin
      bad++; $display("FAIL idle_after_reset: got entry=%0d cnt=%0d want 2 1", entry_val, digit_cnt);
    end
    release_key(DB, 1'b0);
  endtask

  task automatic test_random();
    int code, n, ack_idx, m;
    bit ack;
    for (int it = 0; it < 80; it++) begin
      code    = $urandom_range(0, 15);
      n       = $urandom_range(1, 6);
      ack_idx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : -1;
      press(code, n, ack_idx);
      total++;
      if ({entry_val, digit_cnt, data_out, data_valid, overrun} !==
          {16'(m_entry), 3'(m_cnt), 16'(m_out), m_valid, m_ovr}) begin
        bad++;
        $display("FAIL rand_press it=%0d key=%0h n=%0d: got entry=%0d cnt=%0d out=%0d v=%0b o=%0b want %0d %0d %0d %0b %0b",
                 it, code, n, entry_val, digit_cnt, data_out, data_valid, overrun,
                 m_entry, m_cnt, m_out, m_valid, m_ovr);
      end
      m   = $urandom_range(1, 6);
      ack = ($urandom_range(0, 3) == 0);
      release_key(m, ack);
      total++;
      if ({entry_val, digit_cnt, data_out, data_valid, overrun} !==
          {16'(m_entry), 3'(m_cnt), 16'(m_out), m_valid, m_ovr}) begin
        bad++;
        $display("FAIL rand_release it=%0d m=%0d: got entry=%0d cnt=%0d out=%0d v=%0b o=%0b want %0d %0d %0d %0b %0b",
                 it, m, entry_val, digit_cnt, data_out, data_valid, overrun,
                 m_entry, m_cnt, m_out, m_valid, m_ovr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digit_entry();
    test_short_press();
    test_glitch();
    test_max_digits();
    test_overrun();
    test_ack_same_cycle();
    test_reset_mid_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
